// File: rtl/if_stage_pkg.sv
// Shared fetch-stage types and constants: reset PC default, NOP encoding,
// fetch FSM state enum and the {ins, npc} payload carried by the skid buffer.
package if_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INS      = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP      = 32'd4;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [ILEN-1:0] ins;
    logic [XLEN-1:0] npc;
  } fetch_pkt_t;

  // Fetch addresses are always word-aligned; byte offset bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface if_stage_if;
  import if_stage_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            ready;
  logic            rvalid;
  logic [ILEN-1:0] rdata;

  modport master (output req, addr, input ready, rvalid, rdata);
  modport slave  (input req, addr, output ready, rvalid, rdata);

endinterface

// File: rtl/if_skid_buf.sv
// One-entry {ins, npc} holding register used while decode stalls;
// clear wins over load.
module if_skid_buf
  import if_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       clear,
  input  fetch_pkt_t d,
  output fetch_pkt_t q,
  output logic       valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, single-outstanding imem fetch FSM,
// stall skid buffer and the IF/ID latch feeding decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  if_stage_if.master       imem,
  output logic [ILEN-1:0]  ins,
  output logic [XLEN-1:0]  npc_o,
  output logic             ins_valid
);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt, pc_inc, target;
  logic [ILEN-1:0] ins_nxt;
  logic [XLEN-1:0] npc_nxt;
  logic            valid_nxt;
  logic            accept;
  logic            new_word;
  fetch_pkt_t      new_pkt;
  fetch_pkt_t      skid_d, skid_q;
  logic            skid_load, skid_clear, skid_valid;

  // Request decodes registered state only; no input reaches imem outputs.
  assign imem.req  = (state == ST_REQ);
  assign imem.addr = pc;

  assign accept = (state == ST_REQ) && imem.ready;
  assign pc_inc = pc + PC_STEP;
  assign target = word_align(redirect_pc);
  assign skid_d = '{ins: imem.rdata, npc: pc_inc};

  if_skid_buf u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (skid_d),
    .q     (skid_q),
    .valid (skid_valid)
  );

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    new_word   = 1'b0;
    new_pkt    = skid_q;
    ins_nxt    = ins;
    npc_nxt    = npc_o;
    valid_nxt  = ins_valid;

    case (state)
      ST_REQ: begin
        if (accept) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem.rvalid) begin
          pc_nxt = pc_inc;
          if (stall) begin
            skid_load = 1'b1;
            state_nxt = ST_HOLD;
          end else begin
            new_word  = 1'b1;
            new_pkt   = skid_d;
            state_nxt = ST_REQ;
          end
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          new_word   = skid_valid;
          skid_clear = 1'b1;
          state_nxt  = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (imem.rvalid) state_nxt = ST_REQ;
      end
      default: state_nxt = ST_REQ;
    endcase

    // Redirect overrides everything; an in-flight request becomes an orphan to drain.
    if (redirect) begin
      pc_nxt     = target;
      skid_load  = 1'b0;
      skid_clear = 1'b1;
      new_word   = 1'b0;
      case (state)
        ST_REQ:   state_nxt = accept      ? ST_DRAIN : ST_REQ;
        ST_WAIT:  state_nxt = imem.rvalid ? ST_REQ   : ST_DRAIN;
        ST_HOLD:  state_nxt = ST_REQ;
        ST_DRAIN: state_nxt = imem.rvalid ? ST_REQ   : ST_DRAIN;
        default:  state_nxt = ST_REQ;
      endcase
    end

    // IF/ID latch: flush > hold > load > bubble.
    if (redirect) begin
      ins_nxt   = NOP_INS;
      valid_nxt = 1'b0;
    end else if (stall) begin
      ins_nxt   = ins;
      npc_nxt   = npc_o;
      valid_nxt = ins_valid;
    end else if (new_word) begin
      ins_nxt   = new_pkt.ins;
      npc_nxt   = new_pkt.npc;
      valid_nxt = 1'b1;
    end else begin
      ins_nxt   = NOP_INS;
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_REQ;
      pc        <= word_align(RESET_PC);
      ins       <= NOP_INS;
      npc_o     <= '0;
      ins_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      ins       <= ins_nxt;
      npc_o     <= npc_nxt;
      ins_valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: table vectors, directed corner sequences
// and randomized traffic against a program-order fetch/delivery model.
module tb_if_stage;
  import if_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ins, npc_o, ins2, npc2;
  logic        ins_valid, valid2;

  if_stage_if bus();
  if_stage_if bus2();

  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(bus),
    .ins(ins), .npc_o(npc_o), .ins_valid(ins_valid)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0), .imem(bus2),
    .ins(ins2), .npc_o(npc2), .ins_valid(valid2)
  );

  int checks = 0;
  int errors = 0;

  // memory model and stimulus knobs
  logic        ready;
  int          lat;
  logic        pend_valid;
  logic [31:0] pend_addr;
  int          pend_cnt;
  logic        pend2;
  logic [31:0] pend2_addr;
  logic        ovr_en;
  logic [31:0] ovr_addr, ovr_word;

  // reference model: next address to be accepted, next address to be delivered
  logic [31:0] exp_fetch, exp_deliver;
  int          deliveries, idle;

  // pre-edge snapshot
  logic        s_rst, s_req, s_ready, s_rvalid, s_stall, s_redir, s_req2, s_rvalid2;
  logic [31:0] s_addr, s_tgt, s_ins, s_npc, s_addr2;
  logic        s_valid;

  typedef struct {
    logic        stall;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_ins;
    logic [31:0] exp_npc;
  } vec_t;
  vec_t vecs[14];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (ovr_en && a == ovr_addr) ? ovr_word : a;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic        acc, acc2;
    logic [31:0] tgt;
    bus.ready  = ready;
    bus.rvalid = pend_valid && (pend_cnt == 0);
    bus.rdata  = bus.rvalid ? word_at(pend_addr) : $urandom();
    bus2.ready  = 1'b1;
    bus2.rvalid = pend2;
    bus2.rdata  = pend2_addr;
    @(negedge clk);
    s_rst = rst; s_req = bus.req; s_addr = bus.addr; s_ready = bus.ready;
    s_rvalid = bus.rvalid; s_stall = stall; s_redir = redirect; s_tgt = redirect_pc;
    s_ins = ins; s_npc = npc_o; s_valid = ins_valid;
    s_req2 = bus2.req; s_addr2 = bus2.addr; s_rvalid2 = bus2.rvalid;
    @(posedge clk);
    #1;
    if (s_rst) begin
      pend_valid = 1'b0;
      pend2      = 1'b0;
    end else begin
      acc = s_req && s_ready;
      if (acc) begin
        chk(!pend_valid, "single_outstanding", 32'(pend_valid), 32'h0);
        chk(s_addr == exp_fetch, "fetch_addr", s_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (acc || s_rvalid) idle = 0; else idle++;
      chk(idle <= 64, "progress", 32'(idle), 32'd64);
      if (s_rvalid) pend_valid = 1'b0;
      else if (pend_valid) pend_cnt--;
      if (acc) begin
        pend_valid = 1'b1;
        pend_addr  = s_addr;
        pend_cnt   = lat - 1;
      end
      if (s_redir) begin
        tgt = {s_tgt[31:2], 2'b00};
        exp_fetch   = tgt;
        exp_deliver = tgt;
        chk(!ins_valid && ins == 32'h0, "redirect_flush", ins, 32'h0);
      end else if (s_stall) begin
        chk(ins == s_ins && npc_o == s_npc && ins_valid == s_valid, "stall_hold", ins, s_ins);
      end else if (ins_valid) begin
        chk(ins == word_at(exp_deliver), "deliver_ins", ins, word_at(exp_deliver));
        chk(npc_o == exp_deliver + 32'd4, "deliver_npc", npc_o, exp_deliver + 32'd4);
        exp_deliver = exp_deliver + 32'd4;
        deliveries++;
      end else begin
        chk(ins == 32'h0 && npc_o == s_npc, "bubble", ins, 32'h0);
      end
      acc2 = s_req2;
      if (acc2) begin
        pend2      = 1'b1;
        pend2_addr = s_addr2;
      end else if (s_rvalid2) begin
        pend2 = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_fetch = 32'h0; exp_deliver = 32'h0; idle = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    lat = 1; ovr_en = 1'b0; ovr_addr = 32'h0; ovr_word = 32'h0;
    pend_valid = 1'b0; pend_addr = 32'h0; pend_cnt = 0; pend2 = 1'b0; pend2_addr = 32'h0;
    deliveries = 0; idle = 0;

    // zero-wait sequence plus a 5-cycle stall across a response
    vecs[0]  = '{1'b0, 1'b1, 32'h0,  1'b0, 32'h0,         32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0,         32'h4};
    vecs[2]  = '{1'b0, 1'b1, 32'h4,  1'b0, 32'h0,         32'h4};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h4,         32'h8};
    vecs[4]  = '{1'b0, 1'b1, 32'h8,  1'b0, 32'h0,         32'h8};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8,         32'hC};
    vecs[6]  = '{1'b1, 1'b1, 32'hC,  1'b1, 32'h8,         32'hC};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h8,         32'hC};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h8,         32'hC};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h8,         32'hC};
    vecs[10] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h8,         32'hC};
    vecs[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h2008_0005, 32'h10};
    vecs[12] = '{1'b0, 1'b1, 32'h10, 1'b0, 32'h0,         32'h10};
    vecs[13] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h10,        32'h14};

    do_reset();
    chk(bus.req == 1'b1, "reset_req", 32'(bus.req), 32'h1);
    chk(bus.addr == 32'h0, "reset_addr", bus.addr, 32'h0);
    chk(ins == 32'h0 && npc_o == 32'h0, "reset_latch", ins, 32'h0);
    chk(ins_valid == 1'b0, "reset_valid", 32'(ins_valid), 32'h0);
    chk(bus2.addr == 32'hFFFF_FFFC, "reset_addr_wrapdut", bus2.addr, 32'hFFFF_FFFC);

    ovr_en = 1'b1; ovr_addr = 32'hC; ovr_word = 32'h2008_0005;
    for (int i = 0; i < 14; i++) begin
      stall = vecs[i].stall;
      step();
      chk(s_req == vecs[i].exp_req, $sformatf("vec%0d_req", i), 32'(s_req), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req)
        chk(s_addr == vecs[i].exp_addr, $sformatf("vec%0d_addr", i), s_addr, vecs[i].exp_addr);
      chk(ins_valid == vecs[i].exp_valid, $sformatf("vec%0d_valid", i), 32'(ins_valid), 32'(vecs[i].exp_valid));
      chk(ins == vecs[i].exp_ins, $sformatf("vec%0d_ins", i), ins, vecs[i].exp_ins);
      chk(npc_o == vecs[i].exp_npc, $sformatf("vec%0d_npc", i), npc_o, vecs[i].exp_npc);
    end
    stall = 1'b0;
    ovr_en = 1'b0;

    // redirect in WAIT, orphan response 3 cycles later
    do_reset();
    lat = 4;
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    step(); chk(!s_req, "drain_noreq1", 32'(s_req), 32'h0);
    step(); chk(!s_req, "drain_noreq2", 32'(s_req), 32'h0);
    step(); chk(!s_req && s_rvalid, "drain_orphan", 32'(s_rvalid), 32'h1);
    chk(!ins_valid, "orphan_blocked", 32'(ins_valid), 32'h0);
    step(); chk(s_req && s_addr == 32'h100, "redirect_target", s_addr, 32'h100);
    for (int k = 0; k < 10 && !ins_valid; k++) step();
    chk(ins_valid && ins == 32'h100, "redirect_first_ins", ins, 32'h100);
    lat = 1;

    // redirect together with stall while the skid buffer is full
    do_reset();
    step();
    stall = 1'b1;
    step(); chk(!ins_valid, "hold_bubble", 32'(ins_valid), 32'h0);
    redirect = 1'b1; redirect_pc = 32'h200;
    step(); chk(!ins_valid && ins == 32'h0, "hold_redirect_flush", ins, 32'h0);
    stall = 1'b0; redirect = 1'b0;
    step(); chk(s_req && s_addr == 32'h200, "hold_redirect_addr", s_addr, 32'h200);
    step(); chk(ins_valid && ins == 32'h200 && npc_o == 32'h204, "hold_redirect_ins", ins, 32'h200);

    // redirect while the request is pending on a not-ready memory
    do_reset();
    ready = 1'b0;
    step(); chk(s_req && s_addr == 32'h0, "pend_req0", s_addr, 32'h0);
    step();
    redirect = 1'b1; redirect_pc = 32'h300;
    step();
    redirect = 1'b0;
    step(); chk(s_req && s_addr == 32'h300, "pend_readdr", s_addr, 32'h300);
    ready = 1'b1;
    step(); chk(s_req && s_addr == 32'h300, "pend_accept", s_addr, 32'h300);
    step(); chk(ins_valid && ins == 32'h300, "pend_ins", ins, 32'h300);
    step(); chk(s_req && s_addr == 32'h304, "pend_next", s_addr, 32'h304);

    // PC wrap on the high reset vector instance
    do_reset();
    step();
    step();
    chk(valid2 && ins2 == 32'hFFFF_FFFC, "wrap_ins", ins2, 32'hFFFF_FFFC);
    chk(npc2 == 32'h0, "wrap_npc", npc2, 32'h0);
    step(); chk(s_req2 && s_addr2 == 32'h0, "wrap_addr", s_addr2, 32'h0);

    // randomized traffic with a mid-run reset
    do_reset();
    deliveries = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
      end else begin
        stall       = ($urandom_range(3) == 0);
        redirect    = ($urandom_range(12) == 0);
        redirect_pc = $urandom();
        ready       = ($urandom_range(9) < 7);
        lat         = 1 + int'($urandom_range(3));
        step();
      end
    end
    chk(deliveries >= 50, "random_throughput", 32'(deliveries), 32'd50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
